// File: rtl/pio_pkg.sv
// Shared defaults, edge-select encodings and sizing helpers for the
// programmable I/O synchroniser/controller.
package pio_pkg;

    localparam int NPIO_DEF     = 12;
    localparam int SYNC_STG_DEF = 2;
    localparam int FLT_W_DEF    = 4;

    // Edge-select register encoding, one bit per pin.
    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    // Width of the post-reset priming counter.
    // It must hold the value SYNC_STG+1.
    function automatic int prime_w(input int sync_stg);
        return $clog2(sync_stg + 32'sd2);
    endfunction

endpackage

// File: rtl/pio_sync_ctl_if.sv
// Register-write, pad and status bundle between a host and pio_sync_ctl.
interface pio_sync_ctl_if #(
    parameter int NPIO  = pio_pkg::NPIO_DEF,
    parameter int FLT_W = pio_pkg::FLT_W_DEF
);
    logic [NPIO-1:0]  T_PIOin;
    logic             DIR_wr;
    logic [NPIO-1:0]  DIR_di;
    logic             OUT_wr;
    logic [NPIO-1:0]  OUT_di;
    logic             MASK_wr;
    logic [NPIO-1:0]  MASK_di;
    logic             EDGE_wr;
    logic [NPIO-1:0]  EDGE_di;
    logic             FLT_wr;
    logic [FLT_W-1:0] FLT_di;
    logic [NPIO-1:0]  PEND_clr;
    logic [NPIO-1:0]  PIO_oe;
    logic [NPIO-1:0]  PIO_out;
    logic [NPIO-1:0]  PIO_val;
    logic [NPIO-1:0]  PIO_pend;
    logic             PIO_IRQn;

    modport master (
        output T_PIOin, DIR_wr, DIR_di, OUT_wr, OUT_di, MASK_wr, MASK_di,
               EDGE_wr, EDGE_di, FLT_wr, FLT_di, PEND_clr,
        input  PIO_oe, PIO_out, PIO_val, PIO_pend, PIO_IRQn
    );

    modport slave (
        input  T_PIOin, DIR_wr, DIR_di, OUT_wr, OUT_di, MASK_wr, MASK_di,
               EDGE_wr, EDGE_di, FLT_wr, FLT_di, PEND_clr,
        output PIO_oe, PIO_out, PIO_val, PIO_pend, PIO_IRQn
    );
endinterface

// File: rtl/pio_flt.sv
// One pin: metastability synchroniser, saturating glitch filter and
// edge-event detection on the filtered value.
module pio_flt
    import pio_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF,
    parameter int FLT_W    = FLT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad,
    input  logic [FLT_W-1:0] flt,
    input  logic             prime,
    input  logic             clr,
    input  logic             dir,
    input  logic             edge_sel,
    output logic             val,
    output logic             pend_set
);

    logic [SYNC_STG-1:0] sync_r;
    logic [FLT_W-1:0]    cnt_r;
    logic                val_r;
    logic                s_s;
    logic                upd_s;

    assign s_s = sync_r[SYNC_STG-1];
    assign val = val_r;

    // Shift the raw pad through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STG{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STG-2:0], pad};
        end
    end

    // Decide whether the filtered value takes the sample, and whether that is an event.
    always_comb begin
        upd_s    = 1'b0;
        pend_set = 1'b0;
        if (!prime && !clr && (s_s != val_r) && (cnt_r >= flt)) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
        if (upd_s && !dir &&
            ((s_s && (edge_sel == EDGE_RISE)) || (!s_s && (edge_sel == EDGE_FALL)))) begin
            pend_set = 1'b1;
        end else begin
            pend_set = 1'b0;
        end
    end

    // Filter counter and filtered value; clearing never touches the value itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {FLT_W{1'b0}};
            val_r <= 1'b0;
        end else if (prime) begin
            cnt_r <= {FLT_W{1'b0}};
            val_r <= s_s;
        end else if (clr || (s_s == val_r)) begin
            cnt_r <= {FLT_W{1'b0}};
        end else if (upd_s) begin
            cnt_r <= {FLT_W{1'b0}};
            val_r <= s_s;
        end else if (cnt_r != {FLT_W{1'b1}}) begin
            cnt_r <= cnt_r + FLT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pio_sync_ctl.sv
// Programmable I/O controller: configuration registers, per-pin filtered
// inputs, latched edge-pending flags and an active-low interrupt.
module pio_sync_ctl
    import pio_pkg::*;
#(
    parameter int NPIO     = NPIO_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF,
    parameter int FLT_W    = FLT_W_DEF
) (
    input logic           CLK,
    input logic           RSTn,
    pio_sync_ctl_if.slave bus
);

    localparam int                 PRIME_W    = prime_w(SYNC_STG);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STG + 32'sd1);

    logic [NPIO-1:0]    dir_r;
    logic [NPIO-1:0]    out_r;
    logic [NPIO-1:0]    mask_r;
    logic [NPIO-1:0]    edge_r;
    logic [NPIO-1:0]    pend_r;
    logic [FLT_W-1:0]   flt_r;
    logic               irq_n_r;
    logic [PRIME_W-1:0] prime_cnt_r;
    logic               prime_s;
    logic [NPIO-1:0]    flt_clr_s;
    logic [NPIO-1:0]    pend_set_s;
    logic [NPIO-1:0]    val_s;

    // Priming lasts until the counter reaches SYNC_STG+1, so the chain fills before events count.
    assign prime_s = (prime_cnt_r != PRIME_LAST);

    // Host-visible configuration registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            dir_r  <= {NPIO{1'b0}};
            out_r  <= {NPIO{1'b0}};
            mask_r <= {NPIO{1'b0}};
            edge_r <= {NPIO{EDGE_RISE}};
            flt_r  <= {FLT_W{1'b0}};
        end else begin
            if (bus.DIR_wr)  dir_r  <= bus.DIR_di;
            if (bus.OUT_wr)  out_r  <= bus.OUT_di;
            if (bus.MASK_wr) mask_r <= bus.MASK_di;
            if (bus.EDGE_wr) edge_r <= bus.EDGE_di;
            if (bus.FLT_wr)  flt_r  <= bus.FLT_di;
        end
    end

    // Post-reset priming counter, stops at its terminal value.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            prime_cnt_r <= {PRIME_W{1'b0}};
        end else if (prime_s) begin
            prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    // A new filter length, or a pin turning from output to input, restarts the filter count.
    always_comb begin
        flt_clr_s = {NPIO{bus.FLT_wr}} | ({NPIO{bus.DIR_wr}} & dir_r & ~bus.DIR_di);
    end

    for (genvar i = 0; i < NPIO; i++) begin : g_pin
        pio_flt #(
            .SYNC_STG (SYNC_STG),
            .FLT_W    (FLT_W)
        ) u_flt (
            .clk      (CLK),
            .rst_n    (RSTn),
            .pad      (bus.T_PIOin[i]),
            .flt      (flt_r),
            .prime    (prime_s),
            .clr      (flt_clr_s[i]),
            .dir      (dir_r[i]),
            .edge_sel (edge_r[i]),
            .val      (val_s[i]),
            .pend_set (pend_set_s[i])
        );
    end

    // Pending flags (a new event beats a same-cycle clear) and the registered interrupt.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pend_r  <= {NPIO{1'b0}};
            irq_n_r <= 1'b1;
        end else begin
            pend_r  <= (pend_r & ~bus.PEND_clr) | pend_set_s;
            irq_n_r <= ~|(pend_r & mask_r);
        end
    end

    assign bus.PIO_oe   = dir_r;
    assign bus.PIO_out  = out_r;
    assign bus.PIO_val  = val_s;
    assign bus.PIO_pend = pend_r;
    assign bus.PIO_IRQn = irq_n_r;

endmodule

// File: tb/tb_pio_sync_ctl.sv
// Self-checking bench for pio_sync_ctl with NPIO=12, SYNC_STG=2, FLT_W=4.
module tb_pio_sync_ctl;

    logic        CLK;
    logic        RSTn;
    logic [11:0] pad_r;
    logic        loop_en;

    pio_sync_ctl_if #(.NPIO(12), .FLT_W(4)) bus ();

    pio_sync_ctl #(.NPIO(12), .SYNC_STG(2), .FLT_W(4)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    // Pads: driven by the bench, or looped back from the output driver where enabled.
    assign bus.T_PIOin = loop_en ? ((pad_r & ~bus.PIO_oe) | (bus.PIO_out & bus.PIO_oe)) : pad_r;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] oe;
        logic [11:0] out;
        logic [11:0] val;
        logic [11:0] pend;
        logic        irqn;
    } exp_t;

    typedef struct {
        logic        dir_wr;
        logic [11:0] dir_di;
        logic        out_wr;
        logic [11:0] out_di;
        logic        mask_wr;
        logic [11:0] mask_di;
        logic [11:0] exp_oe;
        logic [11:0] exp_out;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[7];
    int          errors = 0;
    int          checks = 0;
    logic [11:0] e_oe, e_out, e_val, e_pend;
    logic        e_irqn;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the expectation, advance one edge, then compare what the DUT shows.
    task automatic tick_chk(input string nm);
        exp_t ex;
        exp_t got;
        ex.oe   = e_oe;
        ex.out  = e_out;
        ex.val  = e_val;
        ex.pend = e_pend;
        ex.irqn = e_irqn;
        sb_q.push_back(ex);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        cmp({nm, ".oe"},   32'(bus.PIO_oe),   32'(got.oe));
        cmp({nm, ".out"},  32'(bus.PIO_out),  32'(got.out));
        cmp({nm, ".val"},  32'(bus.PIO_val),  32'(got.val));
        cmp({nm, ".pend"}, 32'(bus.PIO_pend), 32'(got.pend));
        cmp({nm, ".irqn"}, 32'(bus.PIO_IRQn), 32'(got.irqn));
    endtask

    task automatic idle();
        bus.DIR_wr   = 1'b0;
        bus.OUT_wr   = 1'b0;
        bus.MASK_wr  = 1'b0;
        bus.EDGE_wr  = 1'b0;
        bus.FLT_wr   = 1'b0;
        bus.PEND_clr = 12'h000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 12'hA5A, 1'b0, 12'h000, 1'b0, 12'h000, 12'hA5A, 12'h000};
        vecs[1] = '{1'b0, 12'hFFF, 1'b1, 12'h3C3, 1'b0, 12'h000, 12'hA5A, 12'h3C3};
        vecs[2] = '{1'b1, 12'h000, 1'b1, 12'hFFF, 1'b0, 12'h000, 12'h000, 12'hFFF};
        vecs[3] = '{1'b0, 12'hFFF, 1'b0, 12'h000, 1'b0, 12'hFFF, 12'h000, 12'hFFF};
        vecs[4] = '{1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 12'hFFF, 12'h000, 12'h001};
        vecs[5] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 1'b0, 12'h000, 12'hFFF, 12'h001};
        vecs[6] = '{1'b1, 12'h000, 1'b1, 12'h000, 1'b0, 12'h000, 12'h000, 12'h000};

        RSTn = 1'b0; loop_en = 1'b0; pad_r = 12'hFFF;
        idle();
        bus.DIR_di = 12'h000; bus.OUT_di = 12'h000; bus.MASK_di = 12'h000;
        bus.EDGE_di = 12'h000; bus.FLT_di = 4'h0;
        e_oe = 12'h000; e_out = 12'h000; e_val = 12'h000; e_pend = 12'h000; e_irqn = 1'b1;

        tick();
        tick_chk("rst");
        // Pins high through reset release: priming loads them without events.
        RSTn = 1'b1;
        tick_chk("prime0");
        tick_chk("prime1");
        e_val = 12'hFFF;
        tick_chk("prime2");
        tick_chk("prime3");
        tick_chk("prime4");

        RSTn = 1'b0; pad_r = 12'h000; e_val = 12'h000;
        tick_chk("rst2");
        RSTn = 1'b1;
        repeat (4) tick();

        // Register write/readback table.
        for (int i = 0; i < 7; i++) begin
            bus.DIR_wr  = vecs[i].dir_wr;  bus.DIR_di  = vecs[i].dir_di;
            bus.OUT_wr  = vecs[i].out_wr;  bus.OUT_di  = vecs[i].out_di;
            bus.MASK_wr = vecs[i].mask_wr; bus.MASK_di = vecs[i].mask_di;
            e_oe = vecs[i].exp_oe; e_out = vecs[i].exp_out;
            tick_chk($sformatf("vec%0d", i));
        end
        idle();

        // Rising edge on pin 3 with bypassed filter.
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h008;
        tick();
        idle();
        pad_r[3] = 1'b1;
        tick_chk("r31_e0");
        tick_chk("r31_e1");
        e_val = 12'h008; e_pend = 12'h008;
        tick_chk("r31_e2");
        e_irqn = 1'b0;
        tick_chk("r31_e3");
        bus.PEND_clr = 12'h008; e_pend = 12'h000;
        tick_chk("r31_clr");
        bus.PEND_clr = 12'h000; e_irqn = 1'b1;
        tick_chk("r31_irq_off");

        // Falling pin with rising-edge select: no event.
        pad_r[3] = 1'b0;
        tick_chk("fall_a");
        tick_chk("fall_b");
        e_val = 12'h000;
        tick_chk("fall_nopend");

        // Falling-edge select, masked pending, then unmask.
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h000;
        bus.EDGE_wr = 1'b1; bus.EDGE_di = 12'hFF7;
        tick_chk("cfg_fall");
        idle();
        pad_r[3] = 1'b1;
        tick_chk("rf_a");
        tick_chk("rf_b");
        e_val = 12'h008;
        tick_chk("rise_no_evt");
        pad_r[3] = 1'b0;
        tick_chk("ff_a");
        tick_chk("ff_b");
        e_val = 12'h000; e_pend = 12'h008;
        tick_chk("fall_pend");
        tick_chk("masked_irq");
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h008;
        tick_chk("unmask");
        idle();
        e_irqn = 1'b0;
        tick_chk("unmask_irq");
        bus.PEND_clr = 12'h008; e_pend = 12'h000;
        tick_chk("fall_clr");
        bus.PEND_clr = 12'h000; e_irqn = 1'b1;
        tick_chk("fall_irq_off");
        bus.EDGE_wr = 1'b1; bus.EDGE_di = 12'hFFF;
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h001;
        tick_chk("cfg_pin0");
        idle();

        // Set beats clear on the same edge.
        pad_r[0] = 1'b1;
        tick_chk("r33_e0");
        tick_chk("r33_e1");
        bus.PEND_clr = 12'h001; e_val = 12'h001; e_pend = 12'h001;
        tick_chk("r33_setwins");
        e_pend = 12'h000; e_irqn = 1'b0;
        tick_chk("r33_clr");
        bus.PEND_clr = 12'h000; e_irqn = 1'b1;
        tick_chk("r33_irq_off");

        // Glitch filter of length 3 on pin 5.
        bus.FLT_wr = 1'b1; bus.FLT_di = 4'h3;
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h020;
        tick_chk("flt3");
        idle();
        pad_r[5] = 1'b1;
        repeat (3) tick_chk("r32_pulse3");
        pad_r[5] = 1'b0;
        repeat (6) tick_chk("r32_glitch");
        pad_r[5] = 1'b1;
        repeat (4) tick_chk("r32_pulse4");
        pad_r[5] = 1'b0;
        tick_chk("r32_e4");
        e_val = 12'h021; e_pend = 12'h020;
        tick_chk("r32_e5");
        e_irqn = 1'b0;
        tick_chk("r32_irq");
        tick_chk("r32_e7");
        tick_chk("r32_e8");
        e_val = 12'h001;
        tick_chk("r32_fall");
        bus.PEND_clr = 12'h020; e_pend = 12'h000;
        tick_chk("r32_clr");
        bus.PEND_clr = 12'h000; e_irqn = 1'b1;
        tick_chk("r32_irq_off");

        // Output pin looped back to its own pad.
        bus.FLT_wr = 1'b1; bus.FLT_di = 4'h0;
        bus.DIR_wr = 1'b1; bus.DIR_di = 12'h004;
        bus.MASK_wr = 1'b1; bus.MASK_di = 12'h004;
        loop_en = 1'b1; e_oe = 12'h004;
        tick_chk("r35_cfg");
        idle();
        bus.OUT_wr = 1'b1; bus.OUT_di = 12'h004; e_out = 12'h004;
        tick_chk("r35_out1");
        idle();
        tick_chk("r35_a");
        tick_chk("r35_b");
        e_val = 12'h005;
        tick_chk("r35_follow");
        bus.OUT_wr = 1'b1; bus.OUT_di = 12'h000; e_out = 12'h000;
        tick_chk("r35_out0");
        idle();
        tick_chk("r35_c");
        tick_chk("r35_d");
        e_val = 12'h001;
        tick_chk("r35_back");
        bus.OUT_wr = 1'b1; bus.OUT_di = 12'h0F0; e_out = 12'h0F0;
        tick_chk("r35_out_f0");
        idle();

        // Reset in the middle of a long filter count on pin 1.
        bus.FLT_wr = 1'b1; bus.FLT_di = 4'h7;
        tick_chk("flt7");
        idle();
        pad_r[1] = 1'b1;
        repeat (4) tick_chk("r36_count");
        RSTn = 1'b0; pad_r = 12'h000;
        e_oe = 12'h000; e_out = 12'h000; e_val = 12'h000; e_pend = 12'h000; e_irqn = 1'b1;
        tick_chk("r36_rst");
        RSTn = 1'b1;
        repeat (12) tick_chk("r36_after");
        // Filter length is back to bypass after reset.
        pad_r[1] = 1'b1;
        tick_chk("r36_e0");
        tick_chk("r36_e1");
        e_val = 12'h002; e_pend = 12'h002;
        tick_chk("r36_flt0");
        tick_chk("r36_masked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
